muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit; responder side of the control unit's issue interface.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_operand_prep.sv | 55 +++++
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: funct3 codes, funct7 tag and iteration FSM states.
package muldiv_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for the iterative core: magnitudes, result sign and the
// architecturally defined divide corner cases that bypass iteration.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] abs_a_c,
   output logic [XLEN-1:0] abs_b_c,
   output logic            neg_c,
   output logic            special_c,
   output logic [XLEN-1:0] special_res_c
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic signed_a;
   logic signed_b;
   logic sign_a;
   logic sign_b;
   logic is_div;
   logic is_rem;
   logic div_by_zero;
   logic div_ovf;

   always_comb begin
      signed_a = (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                 (func3 == F3_DIV)  || (func3 == F3_REM);
      signed_b = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
      sign_a   = signed_a & rs1[XLEN-1];
      sign_b   = signed_b & rs2[XLEN-1];
      // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude.
      abs_a_c  = sign_a ? (XLEN'(0) - rs1) : rs1;
      abs_b_c  = sign_b ? (XLEN'(0) - rs2) : rs2;

      is_div   = func3[2];
      is_rem   = func3[2] & func3[1];
      neg_c    = is_rem ? sign_a : (sign_a ^ sign_b);

      div_by_zero = is_div & (rs2 == '0);
      div_ovf     = is_div & ~func3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
      special_c   = div_by_zero | div_ovf;

      special_res_c = '0;
      if (div_by_zero) begin
         special_res_c = is_rem ? rs1 : '1;
      end else if (div_ovf) begin
         special_res_c = is_rem ? '0 : rs1;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready issue and response handshakes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_func3,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            busy
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2:0]          func3_q, func3_d;
   logic                neg_q, neg_d;
   logic                special_q, special_d;
   logic                resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]     resp_result_q, resp_result_d;
   logic                busy_q, busy_d;
   logic                req_ready_q, req_ready_d;

   logic [XLEN-1:0]     abs_a_c;
   logic [XLEN-1:0]     abs_b_c;
   logic                neg_c;
   logic                special_c;
   logic [XLEN-1:0]     special_res_c;

   logic                accept;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_shift;
   logic [XLEN:0]       div_diff;
   logic [2*XLEN-1:0]   fin_prod;
   logic [XLEN-1:0]     fin_quot;
   logic [XLEN-1:0]     fin_rem;
   logic [XLEN-1:0]     done_result;

   muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
      .func3         (req_func3),
      .rs1           (req_rs1),
      .rs2           (req_rs2),
      .abs_a_c       (abs_a_c),
      .abs_b_c       (abs_b_c),
      .neg_c         (neg_c),
      .special_c     (special_c),
      .special_res_c (special_res_c)
   );

   assign accept    = req_valid & req_ready_q & ~flush;
   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
   assign div_shift = {rem_q, acc_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};

   // Sign fix applied once, on the first DONE cycle, to the unsigned iteration results.
   assign fin_prod  = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
   assign fin_quot  = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign fin_rem   = neg_q ? (XLEN'(0) - rem_q) : rem_q;

   always_comb begin
      done_result = fin_quot;
      if (special_q) begin
         done_result = acc_q[XLEN-1:0];
      end else begin
         case (func3_q)
            F3_MUL:                       done_result = fin_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: done_result = fin_prod[2*XLEN-1:XLEN];
            F3_REM, F3_REMU:              done_result = fin_rem;
            default:                      done_result = fin_quot;
         endcase
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      rem_d         = rem_q;
      opnd_d        = opnd_q;
      func3_d       = func3_q;
      neg_d         = neg_q;
      special_d     = special_q;
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               func3_d = req_func3;
               neg_d   = neg_c;
               cnt_d   = '0;
               rem_d   = '0;
               if (special_c) begin
                  special_d = 1'b1;
                  acc_d     = {XLEN'(0), special_res_c};
                  state_d   = S_DONE;
               end else begin
                  special_d = 1'b0;
                  if (req_func3[2]) begin
                     acc_d  = {XLEN'(0), abs_a_c};
                     opnd_d = abs_b_c;
                  end else begin
                     acc_d  = {XLEN'(0), abs_b_c};
                     opnd_d = abs_a_c;
                  end
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (func3_q[2]) begin
                  rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                  acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
               end else begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (flush) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
            end else if (!resp_valid_q) begin
               resp_result_d = done_result;
               resp_valid_d  = 1'b1;
            end else if (resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
         end
      endcase

      busy_d      = (state_d != S_IDLE);
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         acc_q         <= '0;
         rem_q         <= '0;
         opnd_q        <= '0;
         func3_q       <= F3_MUL;
         neg_q         <= 1'b0;
         special_q     <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         busy_q        <= 1'b0;
         req_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         rem_q         <= rem_d;
         opnd_q        <= opnd_d;
         func3_q       <= func3_d;
         neg_q         <= neg_d;
         special_q     <= special_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         busy_q        <= busy_d;
         req_ready_q   <= req_ready_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign busy        = busy_q;

endmodule
